// File: rtl/psg_bus_pkg.sv
// Shared types and constants for the PSG bus master: FSM state encoding
// and the {bdir,bc1} bus codes driven onto the AY/YM PSG control pins.
package psg_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_GAP1   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_GAP2   = 3'd4
  } psg_state_e;

  // {bdir,bc1} bus codes
  localparam logic [1:0] BUS_INACTIVE = 2'b00;
  localparam logic [1:0] BUS_READ     = 2'b01;
  localparam logic [1:0] BUS_WRITE    = 2'b10;
  localparam logic [1:0] BUS_LATCH    = 2'b11;

  // Bus code used during the ACCESS phase for a given direction.
  function automatic logic [1:0] access_code(input logic is_write);
    return is_write ? BUS_WRITE : BUS_READ;
  endfunction

endpackage

// File: rtl/psg_phase_timer.sv
// Phase timer: loaded with a tick count on phase entry, counts psg_cen
// pulses and flags expiry on the edge that carries the last pulse.
module psg_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       cen,
  output logic       expire
);

  logic [7:0] cnt_q;

  // Expiry is combinational so the FSM can leave the phase on the same
  // edge as the final tick. A zero count (idle) never expires.
  assign expire = cen && (cnt_q == 8'd1);

  // Load has priority so a tick coinciding with phase entry is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cen && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/psg_bus_master.sv
// PSG bus master: turns one register read/write request into the
// LATCH / gap / ACCESS / gap sequence on BDIR/BC1, timed by psg_cen ticks.
//
// Request handshake: a request transfers on the rising CLKSYS edge where
// req_valid && req_ready are both 1. req_ready is 1 only while idle;
// req_write/req_addr/req_data are captured on that edge and may change
// freely afterwards. req_valid while not ready is ignored. Completion is
// signalled by a one-cycle done pulse (with rsp_valid for reads), on the
// same edge req_ready returns high.
module psg_bus_master
  import psg_bus_pkg::*;
#(
  parameter int HOLD_TICKS = 2,
  parameter int GAP_TICKS  = 1
) (
  input  logic       CLKSYS,
  input  logic       RESETBn,
  input  logic       psg_cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_data_o,
  input  logic [7:0] psg_data_i,
  output psg_state_e dbg_state
);

  localparam logic [7:0] HOLD_N = 8'(HOLD_TICKS);
  localparam logic [7:0] GAP_N  = 8'(GAP_TICKS);

  psg_state_e state_q, state_d;

  logic       write_q;
  logic [3:0] addr_q;
  logic [7:0] data_q;

  logic       accept;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_expire;

  logic [1:0] code_d;
  logic [7:0] bus_data_d;
  logic [3:0] latch_addr;
  logic       done_d;
  logic       rsp_valid_d;
  logic       sample_rd;

  psg_phase_timer u_timer (
    .clk      (CLKSYS),
    .rst_n    (RESETBn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cen      (psg_cen),
    .expire   (tmr_expire)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  // Next-state logic and timer reload on every phase entry.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_LATCH;
          tmr_load = 1'b1;
          tmr_val  = HOLD_N;
        end
      end
      ST_LATCH: begin
        if (tmr_expire) begin
          state_d  = ST_GAP1;
          tmr_load = 1'b1;
          tmr_val  = GAP_N;
        end
      end
      ST_GAP1: begin
        if (tmr_expire) begin
          state_d  = ST_ACCESS;
          tmr_load = 1'b1;
          tmr_val  = HOLD_N;
        end
      end
      ST_ACCESS: begin
        if (tmr_expire) begin
          state_d  = ST_GAP2;
          tmr_load = 1'b1;
          tmr_val  = GAP_N;
        end
      end
      ST_GAP2: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus code/data for the state being entered; registered below so they
  // appear on the first cycle of that state. On the accept edge the
  // captured address is not yet valid, so take it from the request.
  always_comb begin
    code_d      = BUS_INACTIVE;
    bus_data_d  = 8'h00;
    latch_addr  = accept ? req_addr : addr_q;
    done_d      = (state_q == ST_GAP2) && tmr_expire;
    rsp_valid_d = done_d && !write_q;
    sample_rd   = (state_q == ST_ACCESS) && tmr_expire && !write_q;
    case (state_d)
      ST_LATCH: begin
        code_d     = BUS_LATCH;
        bus_data_d = {4'h0, latch_addr};
      end
      ST_ACCESS: begin
        code_d     = access_code(write_q);
        bus_data_d = write_q ? data_q : 8'h00;
      end
      default: begin
        code_d     = BUS_INACTIVE;
        bus_data_d = 8'h00;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      write_q <= 1'b0;
      addr_q  <= 4'h0;
      data_q  <= 8'h00;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      data_q  <= req_data;
    end
  end

  // Registered bus outputs and completion pulses.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      psg_bdir   <= 1'b0;
      psg_bc1    <= 1'b0;
      psg_data_o <= 8'h00;
      done       <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      {psg_bdir, psg_bc1} <= code_d;
      psg_data_o <= bus_data_d;
      done       <= done_d;
      rsp_valid  <= rsp_valid_d;
    end
  end

  // Read result capture at the end of the READ phase; held until the next read.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      rsp_data <= 8'h00;
    end else if (sample_rd) begin
      rsp_data <= psg_data_i;
    end
  end

endmodule

// File: tb/tb_psg_bus_master.sv
// Directed testbench for psg_bus_master: checks bus code/data sequences,
// completion pulses, stalls, reset abort and minimum-latency timing.
module tb_psg_bus_master;
  import psg_bus_pkg::*;

  localparam int W = 10;

  logic       clk;
  logic       rst_n;
  logic       psg_cen;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       done, rsp_valid;
  logic [7:0] rsp_data;
  logic       psg_bdir, psg_bc1;
  logic [7:0] psg_data_o, psg_data_i;
  psg_state_e dbg_state;

  logic       f_req_valid, f_req_ready, f_req_write;
  logic [3:0] f_req_addr;
  logic [7:0] f_req_data;
  logic       f_done, f_rsp_valid;
  logic [7:0] f_rsp_data;
  logic       f_bdir, f_bc1;
  logic [7:0] f_data_o;
  psg_state_e f_state;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         cen_mode = 0;
  int         tick = 0;
  logic [7:0] rd_val = 8'h00;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           done_n, rsp_n, done_cyc, rsp_cyc;

  psg_bus_master #(.HOLD_TICKS(2), .GAP_TICKS(1)) dut (
    .CLKSYS(clk), .RESETBn(rst_n), .psg_cen(psg_cen),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .done(done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .psg_bdir(psg_bdir), .psg_bc1(psg_bc1), .psg_data_o(psg_data_o),
    .psg_data_i(psg_data_i), .dbg_state(dbg_state)
  );

  psg_bus_master #(.HOLD_TICKS(1), .GAP_TICKS(1)) dut_fast (
    .CLKSYS(clk), .RESETBn(rst_n), .psg_cen(1'b1),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_data(f_req_data),
    .done(f_done), .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
    .psg_bdir(f_bdir), .psg_bc1(f_bc1), .psg_data_o(f_data_o),
    .psg_data_i(8'h00), .dbg_state(f_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // psg_cen generator and PSG read model (returns rd_val only while READ is driven)
  initial begin
    psg_cen    = 1'b0;
    psg_data_i = 8'hFF;
    forever begin
      @(negedge clk);
      tick++;
      case (cen_mode)
        0:       psg_cen = 1'b0;
        1:       psg_cen = ((tick % 4) == 0);
        default: psg_cen = 1'b1;
      endcase
      psg_data_i = ({psg_bdir, psg_bc1} == BUS_READ) ? rd_val : 8'hFF;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one request on the main DUT, collecting distinct {code,data} values
  task automatic run_txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input int budget);
    logic [W-1:0] cur;
    obs_q.delete();
    done_n = 0; rsp_n = 0; done_cyc = -1; rsp_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_data = ~d;
      end
      if (c == 2) req_valid = 1'b1;
      if (c == 3) req_valid = 1'b0;
      cur = {psg_bdir, psg_bc1, psg_data_o};
      if (obs_q.size() == 0 || cur !== obs_q[obs_q.size()-1]) obs_q.push_back(cur);
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (rsp_valid === 1'b1) begin
        rsp_n++;
        if (rsp_cyc < 0) rsp_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_data = 8'h00;
    f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = 4'h0; f_req_data = 8'h00;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({psg_bdir, psg_bc1, psg_data_o} !== 10'h000) begin
      err_cnt++; $display("FAIL reset_bus: got %h want 000", {psg_bdir, psg_bc1, psg_data_o});
    end
    vec_cnt++;
    if ({done, rsp_valid, rsp_data} !== 10'h000) begin
      err_cnt++; $display("FAIL reset_rsp: got %h want 000", {done, rsp_valid, rsp_data});
    end
    vec_cnt++;
    if (req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      err_cnt++; $display("FAIL reset_idle: ready %b state %0d want 1/0", req_ready, dbg_state);
    end
    vec_cnt++;
    if ({f_done, f_rsp_valid, f_rsp_data, f_bdir, f_bc1, f_data_o} !== 20'h0 || f_req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_fast: got %h ready %b want 0/1",
                          {f_done, f_rsp_valid, f_rsp_data, f_bdir, f_bc1, f_data_o}, f_req_ready);
    end
    rst_n = 1'b1;
    cen_mode = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    run_txn(1'b1, 4'h7, 8'h38, 80);
    exp_q.delete();
    exp_q.push_back({BUS_LATCH, 8'h07});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    exp_q.push_back({BUS_WRITE, 8'h38});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL write_seq_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL write_seq[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (done_n != 1 || rsp_n != 0) begin
      err_cnt++; $display("FAIL write_done: done %0d rsp %0d want 1/0", done_n, rsp_n);
    end
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL write_ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_read();
    rd_val = 8'hA5;
    run_txn(1'b0, 4'h0, 8'hC3, 80);
    exp_q.delete();
    exp_q.push_back({BUS_LATCH, 8'h00});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    exp_q.push_back({BUS_READ, 8'h00});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL read_seq_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL read_seq[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (done_n != 1 || rsp_n != 1 || rsp_cyc != done_cyc) begin
      err_cnt++; $display("FAIL read_pulses: done %0d rsp %0d cyc %0d/%0d want 1/1 same",
                          done_n, rsp_n, rsp_cyc, done_cyc);
    end
    vec_cnt++;
    if (rsp_data !== 8'hA5) begin
      err_cnt++; $display("FAIL read_data: got %h want a5", rsp_data);
    end
    rd_val = 8'h11;
    run_txn(1'b1, 4'h2, 8'h55, 80);
    vec_cnt++;
    if (rsp_data !== 8'hA5 || rsp_n != 0 || done_n != 1) begin
      err_cnt++; $display("FAIL read_hold: data %h rsp %0d done %0d want a5/0/1", rsp_data, rsp_n, done_n);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    bit switched = 0;
    bit checked_next = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h4; req_data = 8'h12;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (switched && !checked_next) begin
        checked_next = 1;
        req_valid = 1'b0;
        vec_cnt++;
        if ({psg_bdir, psg_bc1, psg_data_o} !== {BUS_LATCH, 8'h0D}) begin
          err_cnt++; $display("FAIL b2b_second_accept: got %h want 30d", {psg_bdir, psg_bc1, psg_data_o});
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (!switched) begin
          switched = 1;
          vec_cnt++;
          if ({psg_bdir, psg_bc1} !== BUS_INACTIVE || req_ready !== 1'b1) begin
            err_cnt++; $display("FAIL b2b_gap: code %b ready %b want 00/1", {psg_bdir, psg_bc1}, req_ready);
          end
          req_addr = 4'hD; req_data = 8'h34;
        end else begin
          break;
        end
      end
    end
    req_valid = 1'b0;
    vec_cnt++;
    if (n_done != 2 || !checked_next) begin
      err_cnt++; $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
  endtask

  task automatic test_stall();
    bit stable = 1;
    logic [W-1:0] cur;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_data = 8'h81;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cen_mode = 0;
    @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ({psg_bdir, psg_bc1, psg_data_o} !== {BUS_LATCH, 8'h09} || dbg_state !== ST_LATCH
          || done !== 1'b0) stable = 0;
    end
    vec_cnt++;
    if (!stable) begin
      err_cnt++; $display("FAIL stall_stable: got %h state %0d want 309/1",
                          {psg_bdir, psg_bc1, psg_data_o}, dbg_state);
    end
    cen_mode = 1;
    obs_q.delete();
    done_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cur = {psg_bdir, psg_bc1, psg_data_o};
      if (obs_q.size() == 0 || cur !== obs_q[obs_q.size()-1]) obs_q.push_back(cur);
      if (done === 1'b1) begin
        done_n++;
        break;
      end
    end
    exp_q.delete();
    exp_q.push_back({BUS_LATCH, 8'h09});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    exp_q.push_back({BUS_WRITE, 8'h81});
    exp_q.push_back({BUS_INACTIVE, 8'h00});
    vec_cnt++;
    if (obs_q.size() != exp_q.size() || done_n != 1) begin
      err_cnt++; $display("FAIL stall_resume: len %0d done %0d want 4/1", obs_q.size(), done_n);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL stall_seq[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit found = 0;
    int n_done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h3; req_data = 8'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if ({psg_bdir, psg_bc1} === BUS_WRITE) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (!found) begin
      err_cnt++; $display("FAIL abort_reach_access: got 0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({psg_bdir, psg_bc1, psg_data_o} !== 10'h000 || done !== 1'b0 || req_ready !== 1'b1
        || dbg_state !== ST_IDLE) begin
      err_cnt++; $display("FAIL abort_async: bus %h done %b ready %b want 000/0/1",
                          {psg_bdir, psg_bc1, psg_data_o}, done, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || rsp_valid === 1'b1) n_done++;
    end
    vec_cnt++;
    if (n_done != 0) begin
      err_cnt++; $display("FAIL abort_no_done: got %0d want 0", n_done);
    end
    rd_val = 8'h3C;
    run_txn(1'b0, 4'h5, 8'h00, 80);
    vec_cnt++;
    if (rsp_data !== 8'h3C || done_n != 1 || rsp_n != 1 || obs_q.size() != 4) begin
      err_cnt++; $display("FAIL abort_then_read: data %h done %0d rsp %0d len %0d want 3c/1/1/4",
                          rsp_data, done_n, rsp_n, obs_q.size());
    end
    vec_cnt++;
    if (obs_q.size() > 2 && (obs_q[0] !== {BUS_LATCH, 8'h05} || obs_q[2] !== {BUS_READ, 8'h00})) begin
      err_cnt++; $display("FAIL abort_read_seq: got %h %h want 305 100", obs_q[0], obs_q[2]);
    end
  endtask

  task automatic test_fast_timing();
    logic [W-1:0] f_obs[1:5];
    int f_done_cyc = -1;
    int f_rsp = 0;
    @(negedge clk);
    f_req_valid = 1'b1; f_req_write = 1'b1; f_req_addr = 4'hB; f_req_data = 8'h6E;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        f_req_valid = 1'b0; f_req_addr = 4'h0; f_req_data = 8'h00;
      end
      if (c <= 5) f_obs[c] = {f_bdir, f_bc1, f_data_o};
      if (f_done === 1'b1 && f_done_cyc < 0) f_done_cyc = c;
      if (f_rsp_valid === 1'b1) f_rsp++;
    end
    vec_cnt++;
    if (f_done_cyc != 5 || f_rsp != 0) begin
      err_cnt++; $display("FAIL fast_done_cycle: got %0d rsp %0d want 5/0", f_done_cyc, f_rsp);
    end
    vec_cnt++;
    if (f_obs[1] !== {BUS_LATCH, 8'h0B} || f_obs[2] !== 10'h000) begin
      err_cnt++; $display("FAIL fast_latch: got %h %h want 30b 000", f_obs[1], f_obs[2]);
    end
    vec_cnt++;
    if (f_obs[3] !== {BUS_WRITE, 8'h6E} || f_obs[4] !== 10'h000 || f_obs[5] !== 10'h000) begin
      err_cnt++; $display("FAIL fast_access: got %h %h %h want 26e 000 000", f_obs[3], f_obs[4], f_obs[5]);
    end
    vec_cnt++;
    if (f_req_ready !== 1'b1 || f_state !== ST_IDLE) begin
      err_cnt++; $display("FAIL fast_idle: ready %b state %0d want 1/0", f_req_ready, f_state);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall();
    test_reset_mid_access();
    test_fast_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
